// File: rtl/ssd_bcd_counter.sv
// Two-digit packed-BCD up/down counter stepped by debounced push-buttons.
// Latency: clean press to value change is DEBOUNCE_CYCLES+4 edges; load lands on the next edge.
// No backpressure: buttons are sampled every cycle; the value output is always valid.
//
// Ports:
//   ssd_clk, ssd_rst      single clock, synchronous active-high reset
//   btn_up, btn_down      raw asynchronous bouncing buttons (active high)
//   load, load_value      synchronous preset, packed BCD, nibbles >9 clamp to 9
//   ssd_value_out         packed BCD count, [7:4] tens, [3:0] units
//   step_pulse            one-cycle pulse on each stepped value change
module ssd_bcd_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic       ssd_clk,
  input  logic       ssd_rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] ssd_value_out,
  output logic       step_pulse
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } state_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_prev_q, rise_q;
  logic [DW-1:0] cnt_q [2];

  assign raw = {btn_down, btn_up};

  // Synchroniser, debouncer and rising-edge registers for both buttons.
  always_ff @(posedge ssd_clk) begin
    if (ssd_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      rise_q     <= '0;
      for (int b = 0; b < 2; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      rise_q     <= deb_q & ~deb_prev_q;
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] == deb_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == DB_LAST) begin
          deb_q[b] <= sync2_q[b];
          cnt_q[b] <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + DW'(1);
        end
      end
    end
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t, u;
    t = v[7:4];
    u = v[3:0];
    if (u >= 4'd9) begin
      u = 4'd0;
      t = (t >= 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] t, u;
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd0) begin
      u = 4'd9;
      t = (t == 4'd0) ? 4'd9 : t - 4'd1;
    end else begin
      u = u - 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
    logic [3:0] t, u;
    t = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, u};
  endfunction

  state_t        state_q, state_d;
  logic          dir_q, dir_d;        // 0 = up, 1 = down
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    value_q, value_d;
  logic          step_q, step_d;

  logic step_en, step_down;
  logic held_dir, held_other;

  // Debounced levels of the button being repeated and of the opposing one.
  assign held_dir   = dir_q ? deb_q[1] : deb_q[0];
  assign held_other = dir_q ? deb_q[0] : deb_q[1];

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    value_d   = value_q;
    step_d    = 1'b0;
    step_en   = 1'b0;
    step_down = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A rise while the other button is down (including a simultaneous
        // rise, which implies both levels high) is ignored.
        if (rise_q[0] && !deb_q[1]) begin
          step_en   = 1'b1;
          step_down = 1'b0;
          dir_d     = 1'b0;
          timer_d   = '0;
          state_d   = S_HOLD;
        end else if (rise_q[1] && !deb_q[0]) begin
          step_en   = 1'b1;
          step_down = 1'b1;
          dir_d     = 1'b1;
          timer_d   = '0;
          state_d   = S_HOLD;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!held_dir || held_other) begin
          state_d = S_IDLE;
        end else if (timer_q == ((state_q == S_HOLD) ? HOLD_LAST : REP_LAST)) begin
          step_en   = 1'b1;
          step_down = dir_q;
          timer_d   = '0;
          state_d   = S_REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (step_en) begin
      value_d = step_down ? bcd_dec(value_q) : bcd_inc(value_q);
      step_d  = 1'b1;
    end

    // Load overrides any step decided this cycle and cancels auto-repeat.
    if (load) begin
      value_d = bcd_clamp(load_value);
      state_d = S_IDLE;
      timer_d = '0;
      step_d  = 1'b0;
    end
  end

  always_ff @(posedge ssd_clk) begin
    if (ssd_rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      timer_q <= '0;
      value_q <= 8'h00;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      value_q <= value_d;
      step_q  <= step_d;
    end
  end

  assign ssd_value_out = value_q;
  assign step_pulse    = step_q;

endmodule

// File: tb/tb_ssd_bcd_counter.sv
module tb_ssd_bcd_counter;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic       ssd_clk = 1'b0;
  logic       ssd_rst;
  logic       btn_up;
  logic       btn_down;
  logic       load;
  logic [7:0] load_value;
  wire  [7:0] ssd_value_out;
  wire        step_pulse;

  always #5 ssd_clk = ~ssd_clk;

  ssd_bcd_counter #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .ssd_clk      (ssd_clk),
    .ssd_rst      (ssd_rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .load         (load),
    .load_value   (load_value),
    .ssd_value_out(ssd_value_out),
    .step_pulse   (step_pulse)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pulses = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: integer count 0..99, buttons as sample windows,
  // auto-repeat as a countdown to the next step.
  bit         m_r1 [2];
  bit         m_r2 [2];
  logic [D-1:0] m_win [2];
  int         m_nval [2];
  bit         m_deb [2];
  bit         m_prev [2];
  bit         m_rise [2];
  int         m_val;
  bit         m_hold;
  int         m_dir;
  int         m_cd;
  bit         m_pulse;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_r1[b] = 0; m_r2[b] = 0; m_win[b] = '0; m_nval[b] = 0;
      m_deb[b] = 0; m_prev[b] = 0; m_rise[b] = 0;
    end
    m_val = 0; m_hold = 0; m_dir = 0; m_cd = 0; m_pulse = 0;
  endtask

  task automatic model_step(input int down);
    m_val   = down ? (m_val + 99) % 100 : (m_val + 1) % 100;
    m_pulse = 1;
  endtask

  task automatic model_edge();
    bit raw [2];
    bit od [2];
    bit orise [2];
    bit s;
    int lt, lu;
    raw[0] = btn_up;
    raw[1] = btn_down;
    if (ssd_rst) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 2; b++) begin
      od[b] = m_deb[b];
      orise[b] = m_rise[b];
    end
    for (int b = 0; b < 2; b++) begin
      s = m_r2[b];
      m_r2[b] = m_r1[b];
      m_r1[b] = raw[b];
      m_win[b] = {m_win[b][D-2:0], s};
      if (m_nval[b] < D) m_nval[b]++;
      // Level flips once the last D synchronised samples all disagree with it.
      if (m_nval[b] == D && m_win[b] == {D{s}} && s != od[b]) m_deb[b] = s;
      m_rise[b] = od[b] & ~m_prev[b];
      m_prev[b] = od[b];
    end
    m_pulse = 0;
    if (load) begin
      lt = (load_value[7:4] > 9) ? 9 : int'(load_value[7:4]);
      lu = (load_value[3:0] > 9) ? 9 : int'(load_value[3:0]);
      m_val  = lt * 10 + lu;
      m_hold = 0;
    end else if (!m_hold) begin
      if (orise[0] && !od[1]) begin
        model_step(0); m_hold = 1; m_dir = 0; m_cd = H;
      end else if (orise[1] && !od[0]) begin
        model_step(1); m_hold = 1; m_dir = 1; m_cd = H;
      end
    end else begin
      if (!od[m_dir] || od[1 - m_dir]) begin
        m_hold = 0;
      end else begin
        m_cd--;
        if (m_cd == 0) begin
          model_step(m_dir);
          m_cd = R;
        end
      end
    end
  endtask

  function automatic int exp_out();
    logic [3:0] t, u;
    t = 4'(m_val / 10);
    u = 4'(m_val % 10);
    return int'({t, u});
  endfunction

  task automatic tick();
    @(posedge ssd_clk);
    model_edge();
    #1;
    cyc++;
    if (step_pulse) pulses++;
    chk("value", int'(ssd_value_out), exp_out());
    chk("pulse", int'(step_pulse), int'(m_pulse));
  endtask

  task automatic idle(input int n);
    btn_up = 0;
    btn_down = 0;
    repeat (n) tick();
  endtask

  task automatic load_val(input logic [7:0] v);
    load = 1;
    load_value = v;
    tick();
    load = 0;
  endtask

  task automatic set_btn(input int b, input bit v);
    if (b == 0) btn_up = v;
    else btn_down = v;
  endtask

  // Clean press long enough for exactly one step, then release and settle.
  task automatic tap(input int b);
    set_btn(b, 1);
    repeat (9) tick();
    set_btn(b, 0);
    idle(15);
  endtask

  initial begin
    int n, p, second, last, v0, len, b;
    ssd_rst = 1; btn_up = 0; btn_down = 0; load = 0; load_value = 8'h00;
    model_reset();
    repeat (3) tick();
    ssd_rst = 0;
    chk("rst_value", int'(ssd_value_out), 8'h00);
    chk("rst_pulse", int'(step_pulse), 0);

    p = pulses;
    idle(20);
    chk("idle_pulses", pulses - p, 0);
    chk("idle_value", int'(ssd_value_out), 8'h00);

    // Carry and press latency.
    load_val(8'h09);
    btn_up = 1;
    n = 0;
    while (ssd_value_out != 8'h10 && n < 20) begin tick(); n++; end
    chk("press_latency", n, 8);
    chk("carry", int'(ssd_value_out), 8'h10);
    btn_up = 0;
    idle(15);

    load_val(8'h99); tap(0);
    chk("wrap_up", int'(ssd_value_out), 8'h00);
    load_val(8'h00); tap(1);
    chk("wrap_down", int'(ssd_value_out), 8'h99);

    // Bounce shorter than the debounce window.
    v0 = int'(ssd_value_out); p = pulses;
    btn_up = 1; repeat (3) tick();
    btn_up = 0; repeat (2) tick();
    btn_up = 1; repeat (2) tick();
    idle(12);
    chk("bounce_pulses", pulses - p, 0);
    chk("bounce_value", int'(ssd_value_out), v0);

    // Hold and auto-repeat.
    load_val(8'h05);
    btn_up = 1;
    n = 0;
    while (!step_pulse && n < 20) begin tick(); n++; end
    chk("first_step_lat", n, 8);
    chk("first_value", int'(ssd_value_out), 8'h06);
    p = pulses; second = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (step_pulse && second < 0) second = i;
    end
    chk("second_step", second, 10);
    chk("hold_steps", pulses - p, 7);
    chk("hold_value", int'(ssd_value_out), 8'h13);
    btn_up = 0; last = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (step_pulse) last = i;
    end
    chk("stop_in_time", int'(last <= D + 3), 1);
    idle(5);

    // Both buttons together.
    p = pulses; v0 = int'(ssd_value_out);
    btn_up = 1; btn_down = 1;
    repeat (15) tick();
    chk("both_pulses", pulses - p, 0);
    chk("both_value", int'(ssd_value_out), v0);
    idle(12);

    // Opposing button aborts auto-repeat.
    btn_up = 1;
    repeat (22) tick();
    btn_down = 1;
    repeat (8) tick();
    p = pulses;
    repeat (15) tick();
    chk("abort_pulses", pulses - p, 0);
    idle(12);

    load_val(8'hAF);
    chk("clamp", int'(ssd_value_out), 8'h99);

    // Load lands on the edge the step would have happened.
    load_val(8'h30);
    btn_up = 1;
    repeat (7) tick();
    load = 1; load_value = 8'h55;
    tick();
    load = 0;
    chk("load_wins_val", int'(ssd_value_out), 8'h55);
    chk("load_wins_pulse", int'(step_pulse), 0);
    btn_up = 0;
    idle(15);
    chk("load_aborts", int'(ssd_value_out), 8'h55);

    // Reset in REPEAT with the button kept down.
    btn_up = 1;
    repeat (25) tick();
    ssd_rst = 1;
    tick();
    ssd_rst = 0;
    chk("rst_mid_value", int'(ssd_value_out), 8'h00);
    p = pulses;
    repeat (6) tick();
    chk("rst_no_early", pulses - p, 0);
    repeat (10) tick();
    chk("rst_one_step", pulses - p, 1);
    chk("rst_step_value", int'(ssd_value_out), 8'h01);
    idle(15);

    // Randomised activity, checked cycle by cycle against the model.
    for (int it = 0; it < 160; it++) begin
      case ($urandom_range(0, 9))
        0: load_val(8'($urandom));
        1: begin
          ssd_rst = 1;
          repeat ($urandom_range(1, 2)) tick();
          ssd_rst = 0;
        end
        2, 3, 4, 5: begin
          b = $urandom_range(0, 1);
          len = $urandom_range(1, 45);
          for (int k = 0; k < len; k++) begin
            set_btn(b, (k < 4) ? 1'($urandom) : 1'b1);
            if ($urandom_range(0, 19) == 0) begin
              load = 1;
              load_value = 8'($urandom);
            end
            tick();
            load = 0;
          end
          set_btn(b, 0);
        end
        6: begin
          btn_up = 1; btn_down = 1;
          repeat ($urandom_range(2, 20)) tick();
          idle(2);
        end
        7: begin
          b = $urandom_range(0, 1);
          set_btn(b, 1);
          repeat ($urandom_range(5, 30)) tick();
          set_btn(1 - b, 1);
          repeat ($urandom_range(1, 15)) tick();
          idle(2);
        end
        default: idle($urandom_range(1, 12));
      endcase
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_bcd_counter.md
# ssd_bcd_counter

Two-digit packed-BCD up/down counter driven by raw push-buttons; it produces the 8-bit value that the two-digit seven-segment driver displays, with one BCD digit per nibble. It synchronises and debounces the two buttons and steps once per press. A held button auto-repeats. A synchronous load path presets the value. It sits directly upstream of the seven-segment driver and shares its clock.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles required before a debounced level changes (≥2)
- HOLD_CYCLES, 50000000, cycles a button must stay held after its first step before auto-repeat starts (≥2)
- REPEAT_CYCLES, 10000000, cycles between auto-repeat steps (≥2)
- ssd_clk  in  1  single clock; all logic on its rising edge
- ssd_rst  in  1  synchronous, active-high reset
- btn_up  in  1  raw, asynchronous, bouncing up button; active high
- btn_down  in  1  raw, asynchronous, bouncing down button; active high
- load  in  1  synchronous preset strobe
- load_value  in  8  packed BCD preset, [7:4] tens, [3:0] units
- ssd_value_out  out  8  packed BCD count, [7:4] tens, [3:0] units; connects to the driver's 8-bit input
- step_pulse  out  1  one-cycle pulse on every cycle in which ssd_value_out changes because of a step (not on load)

## Operation
- Each button passes through a 2-flop synchroniser, then an independent debouncer.
- Debouncer: a counter is cleared whenever the synchronised level equals the debounced level, and increments otherwise. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised level and the counter clears.
- Rising edges of the debounced levels (rise_up, rise_dn) feed the step FSM. Edge registers reset to 0.
- Step FSM has states IDLE, HOLD and REPEAT, plus a registered direction bit dir and a shared timer.
  - IDLE, rise_up with debounced down low: step up, dir=up, timer=0, go to HOLD. rise_dn with debounced up low: mirror of this.
  - IDLE, rising edge while the other button's debounced level is high, or both rise in the same cycle: no step, stay in IDLE.
  - HOLD: if the dir button is released or the other button's debounced level goes high, go to IDLE with no step. Otherwise, when timer = HOLD_CYCLES-1: step, timer=0, go to REPEAT. Otherwise timer+1.
  - REPEAT: the same release/abort rule applies. Otherwise, when timer = REPEAT_CYCLES-1: step, timer=0. Otherwise timer+1.
- BCD arithmetic:
  - Up: units 9 → 0 with carry into tens; 99 → 00 (wrap).
  - Down: units 0 → 9 with borrow; 00 → 99 (wrap).
  - Nibbles never hold A–F.
- Load: ssd_value_out ← load_value, with each nibble >9 clamped to 9. The FSM goes to IDLE and the timer clears. No step_pulse.
- Priority: ssd_rst > load > step.
- Reset values:
  - ssd_value_out = 8'h00, step_pulse = 0.
  - FSM = IDLE, dir = up, timer = 0.
  - Synchroniser flops, debounced levels and debounce counters all 0.
- Reset asserted mid-HOLD or mid-REPEAT: all state returns to reset values on that edge. A button still held after reset is released needs a fresh debounced rising edge (0→1) to step; holding through reset produces one step once debounced high again, because the debounced level was cleared.

## Timing
- Raw button change to synchronised level: 2 edges.
- Debounced level changes DEBOUNCE_CYCLES edges after the synchronised level settles.
- Debounced rise to ssd_value_out update: 2 edges (edge register, then value register). step_pulse is asserted in the same cycle the new value first appears.
- Clean press to value change: DEBOUNCE_CYCLES+4 edges total.
- After the first step, the second step follows HOLD_CYCLES edges later. Subsequent steps follow every REPEAT_CYCLES edges.
- A load takes effect on the next edge. ssd_value_out is registered only and has no combinational path from inputs.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles never change a debounced level.

## Test plan
(Use DEBOUNCE=4, HOLD=10, REPEAT=3.)
- Reset, then idle 20 cycles → ssd_value_out=8'h00 and step_pulse never asserted.
- Load 8'h09, clean up press → 8'h10 exactly 8 edges after press, one step_pulse. Load 8'h99 + up → 8'h00. Load 8'h00 + down → 8'h99.
- Bounce btn_up high for 3 cycles, low 2, high 2, then low → no value change, no step_pulse.
- Hold btn_up from 8'h05 for 30 cycles after the first step → steps at +0, +10, +13, +16, ... (8'h06, 8'h07, ...). Release → stepping stops within DEBOUNCE+3 edges.
- Press both buttons in the same cycle → no change. While holding up in REPEAT, press down → FSM returns to IDLE with no further steps.
- Load 8'hAF → 8'h99. load and a step in the same cycle → load value wins, no step_pulse. Assert ssd_rst mid-REPEAT → 8'h00 next edge, no steps until a new debounced press.
